// File: rtl/axis_ad_serial_rx.sv
// axis_ad_serial_rx: four-lane simultaneous-sampling serial ADC reader producing extended 32-bit AXI-stream samples.
module axis_ad_serial_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SCLK_DIV    = 2,
  parameter int CONV_CYCLES = 4,
  parameter bit SIGNED      = 1
) (
  input  logic        a_clk,
  input  logic        reset,
  input  logic        trigger,
  output logic        adc_cnv,
  output logic        adc_csn,
  output logic        adc_sck,
  input  logic [3:0]  adc_sdo,
  output logic [31:0] M_AXIS1_tdata,
  output logic [31:0] M_AXIS2_tdata,
  output logic [31:0] M_AXIS3_tdata,
  output logic [31:0] M_AXIS4_tdata,
  output logic        M_AXIS1_tvalid,
  output logic        M_AXIS2_tvalid,
  output logic        M_AXIS3_tvalid,
  output logic        M_AXIS4_tvalid,
  output logic        ready,
  output logic [31:0] sample_count
);
  typedef enum logic [2:0] {IDLE, CONV, CSWAIT, SHIFT, DONE} state_t;
  state_t                st;
  logic [15:0]           cnt;
  logic [5:0]            nbit;
  logic                  hi;
  logic                  tv;
  logic [DATA_WIDTH-1:0] sr [4];
  logic [31:0]           td [4];

  // Upper-bit mask is empty when DATA_WIDTH is 32, so no extension happens.
  function automatic logic [31:0] ext(input logic [DATA_WIDTH-1:0] w);
    logic [32:0] m;
    m = ~((33'd1 << DATA_WIDTH) - 33'd1);
    return 32'(w) | ((SIGNED && w[DATA_WIDTH-1]) ? m[31:0] : 32'd0);
  endfunction

  always_ff @(posedge a_clk) begin
    if (reset) begin
      st           <= IDLE;
      adc_cnv      <= 1'b0;
      adc_csn      <= 1'b1;
      adc_sck      <= 1'b0;
      ready        <= 1'b1;
      tv           <= 1'b0;
      sample_count <= 32'd0;
      cnt          <= 16'd0;
      nbit         <= 6'd0;
      hi           <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        sr[i] <= '0;
        td[i] <= 32'd0;
      end
    end else begin
      tv <= 1'b0;
      case (st)
        IDLE: if (trigger) begin
          st      <= CONV;
          adc_cnv <= 1'b1;
          ready   <= 1'b0;
          cnt     <= 16'(CONV_CYCLES - 1);
        end
        CONV: if (cnt == 16'd0) begin
          st      <= CSWAIT;
          adc_cnv <= 1'b0;
          adc_csn <= 1'b0;
        end else cnt <= cnt - 16'd1;
        CSWAIT: begin
          st   <= SHIFT;
          cnt  <= 16'd0;
          nbit <= 6'd0;
          hi   <= 1'b0;
          for (int i = 0; i < 4; i++) sr[i] <= '0;
        end
        SHIFT: if (cnt == 16'(SCLK_DIV - 1)) begin
          cnt     <= 16'd0;
          hi      <= !hi;
          adc_sck <= !hi;
          // Sample on the edge that raises SCK; the ADC updates on the falling edge.
          if (!hi) for (int i = 0; i < 4; i++) sr[i] <= DATA_WIDTH'({sr[i], adc_sdo[i]});
          else if (nbit == 6'(DATA_WIDTH - 1)) begin
            st           <= DONE;
            adc_csn      <= 1'b1;
            tv           <= 1'b1;
            sample_count <= sample_count + 32'd1;
            for (int i = 0; i < 4; i++) td[i] <= ext(sr[i]);
          end else nbit <= nbit + 6'd1;
        end else cnt <= cnt + 16'd1;
        DONE: begin
          st    <= IDLE;
          ready <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign M_AXIS1_tdata  = td[0];
  assign M_AXIS2_tdata  = td[1];
  assign M_AXIS3_tdata  = td[2];
  assign M_AXIS4_tdata  = td[3];
  assign M_AXIS1_tvalid = tv;
  assign M_AXIS2_tvalid = tv;
  assign M_AXIS3_tvalid = tv;
  assign M_AXIS4_tvalid = tv;
endmodule
